// File: rtl/seq_detector_param.sv
// seq_detector_param: parameterised Mealy serial-pattern detector.
// Uses a KMP-style prefix automaton whose transition table is built at
// elaboration. Overlap or non-overlap restart is chosen per detection.
// Also provides a registered detect flag and a saturating detection counter.
`timescale 1ns/1ps

module seq_detector_param #(
  parameter int                 SEQ_LEN = 5,
  parameter logic [SEQ_LEN-1:0] PATTERN = 5'b10110,
  parameter int                 CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_seq,
  input  logic                      overlap_en,
  input  logic                      count_clr,
  output logic                      det_out,
  output logic                      det_reg,
  output logic [CNT_W-1:0]          det_count,
  output logic [$clog2(SEQ_LEN):0]  match_len
);

  // Width of a matched-prefix length; it must be able to hold SEQ_LEN itself.
  localparam int LW = $clog2(SEQ_LEN) + 1;
  localparam int TW = 2 * SEQ_LEN * LW;

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic logic patBit(input int i);
    return 1'(PATTERN >> (SEQ_LEN - 1 - i));
  endfunction

  // One entry per (state, bit) pair, packed at index 2*s+b.
  // Each entry is the longest pattern prefix that is a suffix of prefix_s followed by b.
  function automatic logic [TW-1:0] buildDelta();
    logic [TW-1:0] tbl;
    logic [TW-1:0] ent;
    int            best;
    int            j;
    logic          ok;
    logic          tBit;
    tbl = '0;
    for (int s = 0; s < SEQ_LEN; s++) begin
      for (int b = 0; b < 2; b++) begin
        best = 0;
        for (int k = 1; k <= s + 1; k++) begin
          ok = 1'b1;
          for (int i = 0; i < k; i++) begin
            j    = s + 1 - k + i;
            tBit = (j == s) ? b[0] : patBit(j);
            if (patBit(i) != tBit) ok = 1'b0;
          end
          if (ok) best = k;
        end
        ent = '0;
        ent[LW-1:0] = LW'(best);
        tbl = tbl | (ent << ((2 * s + b) * LW));
      end
    end
    return tbl;
  endfunction

  // Longest proper border of the pattern; this is the restart state after an overlapping hit.
  function automatic logic [LW-1:0] calcBorder();
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k < SEQ_LEN; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (patBit(i) != patBit(SEQ_LEN - k + i)) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return LW'(best);
  endfunction

  localparam logic [TW-1:0] DELTA  = buildDelta();
  localparam logic [LW-1:0] BORDER = calcBorder();
  localparam logic [LW-1:0] FULL   = LW'(SEQ_LEN);

  logic [LW-1:0]    r_state;
  logic             r_detReg;
  logic [CNT_W-1:0] r_count;

  logic [LW-1:0]    w_nextState;
  logic [LW-1:0]    w_n;
  logic             w_bit;
  logic             w_det;
  int               w_idx;

  // Match-state register; reset drops any partial match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= '0;
    else      r_state <= w_nextState;
  end

  // Table lookup, detect decision and next state; idle cycles hold state and ignore in_seq.
  always_comb begin
    w_bit       = in_valid & in_seq;
    w_idx       = 2 * int'(r_state) + int'(w_bit);
    w_n         = LW'(DELTA >> (w_idx * LW));
    w_det       = 1'b0;
    w_nextState = r_state;
    if (in_valid) begin
      if (w_n == FULL) begin
        w_det       = rst;
        w_nextState = overlap_en ? BORDER : '0;
      end else begin
        w_nextState = w_n;
      end
    end
  end

  // Registered copy of the Mealy detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_detReg <= 1'b0;
    else      r_detReg <= w_det;
  end

  // Saturating detection counter; clear beats a coincident detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          r_count <= '0;
    else if (count_clr)                r_count <= '0;
    else if (w_det && (r_count != '1)) r_count <= r_count + 1'b1;
  end

  assign det_out   = w_det;
  assign det_reg   = r_detReg;
  assign det_count = r_count;
  assign match_len = r_state;

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param with pattern 10110.
// Two instances share one set of inputs: an 8-bit-counter instance and a
// 2-bit-counter instance. The second one exercises counter saturation.
`timescale 1ns/1ps

module tb_seq_detector_param;

  logic clk;
  logic rst;
  logic in_valid;
  logic in_seq;
  logic overlap_en;
  logic count_clr;

  logic       detOutA, detRegA, detOutB, detRegB;
  logic [7:0] countA;
  logic [1:0] countB;
  logic [3:0] lenA, lenB;

  typedef struct {
    bit    det;
    int    len;
    int    cntA;
    int    cntB;
    string name;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  bit   havePending;
  int   checks;
  int   passes;
  int   mCntA;
  int   mCntB;

  seq_detector_param #(.SEQ_LEN(5), .PATTERN(5'b10110), .CNT_W(8)) dutA (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq),
    .overlap_en(overlap_en), .count_clr(count_clr),
    .det_out(detOutA), .det_reg(detRegA), .det_count(countA), .match_len(lenA)
  );

  seq_detector_param #(.SEQ_LEN(5), .PATTERN(5'b10110), .CNT_W(2)) dutB (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq),
    .overlap_en(overlap_en), .count_clr(count_clr),
    .det_out(detOutB), .det_reg(detRegB), .det_count(countB), .match_len(lenB)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    else             passes++;
  endtask

  // Drives one cycle of inputs just after the edge and queues the expected response.
  task automatic applyStimulus(input bit v, input bit s, input bit ov, input bit clr,
                               input bit expDet, input int expLen, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid   = v;
    in_seq     = s;
    overlap_en = ov;
    count_clr  = clr;
    if (clr) begin
      mCntA = 0;
      mCntB = 0;
    end else if (expDet) begin
      if (mCntA < 255) mCntA++;
      if (mCntB < 3)   mCntB++;
    end
    e.det  = expDet;
    e.len  = expLen;
    e.cntA = mCntA;
    e.cntB = mCntB;
    e.name = name;
    q.push_back(e);
  endtask

  // Feeds a continuous valid bit string with per-bit expected match_len and detect.
  task automatic sendBits(input string bits, input string lens, input string dets,
                          input bit ov, input bit clrLast, input string name);
    for (int i = 0; i < bits.len(); i++) begin
      applyStimulus(1'b1, bits[i] == 8'h31, ov, clrLast && (i == bits.len() - 1),
                    dets[i] == 8'h31, int'(lens[i]) - 48, $sformatf("%s[%0d]", name, i + 1));
    end
  endtask

  // Asserts reset for 3 ns between edges and checks that the outputs clear at once.
  task automatic resetPulse(input string name);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    count_clr = 1'b0;
    #5;
    rst = 1'b0;
    #1;
    checkOutput({name, " lenA"},    32'(lenA),    0);
    checkOutput({name, " lenB"},    32'(lenB),    0);
    checkOutput({name, " countA"},  32'(countA),  0);
    checkOutput({name, " countB"},  32'(countB),  0);
    checkOutput({name, " detRegA"}, 32'(detRegA), 0);
    checkOutput({name, " detOutA"}, 32'(detOutA), 0);
    #2;
    rst   = 1'b1;
    mCntA = 0;
    mCntB = 0;
  endtask

  // Monitor: mid-cycle, check det_out for the popped record, then registered outputs one cycle later.
  initial begin
    havePending = 1'b0;
    forever begin
      @(negedge clk);
      if (havePending) begin
        checkOutput({pend.name, " det_reg A"},   32'(detRegA), 32'(pend.det));
        checkOutput({pend.name, " det_reg B"},   32'(detRegB), 32'(pend.det));
        checkOutput({pend.name, " match_len A"}, 32'(lenA),    pend.len);
        checkOutput({pend.name, " match_len B"}, 32'(lenB),    pend.len);
        checkOutput({pend.name, " det_count A"}, 32'(countA),  pend.cntA);
        checkOutput({pend.name, " det_count B"}, 32'(countB),  pend.cntB);
        havePending = 1'b0;
      end
      if (q.size() > 0) begin
        pend = q.pop_front();
        checkOutput({pend.name, " det_out A"}, 32'(detOutA), 32'(pend.det));
        checkOutput({pend.name, " det_out B"}, 32'(detOutB), 32'(pend.det));
        havePending = 1'b1;
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    checks     = 0;
    passes     = 0;
    mCntA      = 0;
    mCntB      = 0;
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_seq     = 1'b0;
    overlap_en = 1'b0;
    count_clr  = 1'b0;

    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset det_out",   32'(detOutA), 0);
    checkOutput("reset det_reg",   32'(detRegA), 0);
    checkOutput("reset det_count", 32'(countA),  0);
    checkOutput("reset match_len", 32'(lenA),    0);
    @(negedge clk);
    #1;
    rst = 1'b1;

    // Non-overlapping, back-to-back patterns.
    sendBits("1011010110", "1234012340", "0000100001", 1'b0, 1'b0, "nonovl");
    // Overlapping: the restart at the border lets 110 complete a second hit.
    sendBits("10110110", "12342342", "00001001", 1'b1, 1'b0, "ovl");
    resetPulse("rstA");
    // Same stream without overlap: only one hit, leaving match_len 2.
    sendBits("10110110", "12340112", "00001000", 1'b0, 1'b0, "ovl0");
    resetPulse("rstB");
    // Mismatch fallback through the KMP table; no false hit on bit 4.
    sendBits("1010110", "1232340", "0000001", 1'b0, 1'b0, "fallback");

    // Invalid gaps with in_seq held high must be ignored.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, "gap v1");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, "gap v2");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, "gap idle");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3, "gap v3");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4, "gap v4");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, "gap v5");

    // Clear, then saturate the 2-bit counter, then clear on a detection cycle.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, "clr");
    for (int i = 0; i < 5; i++) sendBits("10110", "12340", "00001", 1'b0, 1'b0, $sformatf("sat%0d", i + 1));
    sendBits("10110", "12340", "00001", 1'b0, 1'b1, "clrhit");

    // Reset mid-pattern discards progress.
    sendBits("1011", "1234", "0000", 1'b0, 1'b0, "pre");
    resetPulse("rstMid");
    sendBits("0", "0", "0", 1'b0, 1'b0, "post0");
    sendBits("10110", "12340", "00001", 1'b0, 1'b0, "post");

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "idle");

    for (int i = 0; i < 20 && (q.size() != 0 || havePending); i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0 || havePending) begin
      checks++;
      $display("[TB] FAIL drain: %0d records left, expected 0", q.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
